// File: rtl/riscv_dmem.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dmem
// Purpose  : Zero-wait-state single-port data memory for the five-stage riscv
//            core. Loads return combinationally in the request cycle; stores
//            are posted through a one-entry write buffer that forwards to loads
//            in the following cycle and commits to the array one edge later.
//            Any access that is misaligned or beyond the array is dropped and
//            raises a sticky error flag.
// Config   : `define DMEM_MMIO_EN to build the MMIO window at 0xFFFF_FFF0..FC:
//              F0 cycle counter (RO), F4 committed-store counter (RO),
//              F8 {31'b0, err} (any store clears err), FC reserved (reads 0).
//            Without the macro no counters exist and that window is an error.
// Ports    : clk    - clock, rising edge
//            reset  - synchronous, active-high
//            wr     - store request        re    - load request
//            addr   - byte address          wdata - store data
//            rdata  - load data (combinational, 0 when re is low or on error)
//            err    - sticky access-error flag (registered)
// Revision : 1.0 - initial release
// ============================================================================
module riscv_dmem #(
  parameter int ADDR_BITS = 10,
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic                 re,
  input  logic [BUS_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0] wdata,
  output logic [BUS_WIDTH-1:0] rdata,
  output logic                 err
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Storage array: deliberately not reset.
  logic [BUS_WIDTH-1:0] mem_q [DEPTH];

  // Write buffer and error flag.
  logic                 wb_valid_q, wb_valid_d;
  logic [ADDR_BITS-1:0] wb_idx_q,   wb_idx_d;
  logic [BUS_WIDTH-1:0] wb_data_q,  wb_data_d;
  logic                 err_q,      err_d;

  logic [ADDR_BITS-1:0] widx;
  logic                 in_range;
  logic                 acc_err;
  logic                 err_clr;
  logic                 commit;

  assign widx     = addr[ADDR_BITS+1:2];
  assign in_range = (addr[1:0] == 2'b00) && (addr[BUS_WIDTH-1:ADDR_BITS+2] == '0);
  // A pending entry is discarded when reset is asserted on its commit edge.
  assign commit   = wb_valid_q && !reset;

`ifdef DMEM_MMIO_EN
  logic [BUS_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [BUS_WIDTH-1:0] st_cnt_q,  st_cnt_d;
  logic                 mmio_sel;
  logic [BUS_WIDTH-1:0] mmio_rdata;

  assign mmio_sel = (addr[BUS_WIDTH-1:4] == {(BUS_WIDTH-4){1'b1}}) && (addr[1:0] == 2'b00);
  assign acc_err  = (wr || re) && !in_range && !mmio_sel;
  assign err_clr  = wr && mmio_sel && (addr[3:2] == 2'b10);

  always_comb begin
    mmio_rdata = '0;
    case (addr[3:2])
      2'b00:   mmio_rdata = cyc_cnt_q;
      2'b01:   mmio_rdata = st_cnt_q;
      2'b10:   mmio_rdata = {{(BUS_WIDTH-1){1'b0}}, err_q};
      default: mmio_rdata = '0;
    endcase
  end

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + {{(BUS_WIDTH-1){1'b0}}, 1'b1};
    st_cnt_d  = st_cnt_q + {{(BUS_WIDTH-1){1'b0}}, commit};
    if (reset) begin
      cyc_cnt_d = '0;
      st_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    cyc_cnt_q <= cyc_cnt_d;
    st_cnt_q  <= st_cnt_d;
  end
`else
  assign acc_err = (wr || re) && !in_range;
  assign err_clr = 1'b0;
`endif

  // Read path. A simultaneous store to the same word is not yet buffered, so
  // the load naturally sees the pre-store value.
  always_comb begin
    rdata = '0;
    if (re) begin
      if (in_range) begin
        if (wb_valid_q && (wb_idx_q == widx)) begin
          rdata = wb_data_q;
        end else begin
          rdata = mem_q[widx];
        end
      end
`ifdef DMEM_MMIO_EN
      else if (mmio_sel) begin
        rdata = mmio_rdata;
      end
`endif
    end
  end

  // Next-state: capture in-range stores; a new error wins over an MMIO clear.
  always_comb begin
    wb_valid_d = wr && in_range;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    if (wr && in_range) begin
      wb_idx_d  = widx;
      wb_data_d = wdata;
    end

    err_d = err_q;
    if (acc_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    if (reset) begin
      wb_valid_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    wb_valid_q <= wb_valid_d;
    wb_idx_q   <= wb_idx_d;
    wb_data_q  <= wb_data_d;
    err_q      <= err_d;
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[wb_idx_q] <= wb_data_q;
    end
  end

  assign err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_dmem
// Purpose  : Directed self-checking bench for riscv_dmem: reset state, store
//            forwarding, array reads, back-to-back stores, simultaneous
//            load/store, access errors, reset during a pending store and the
//            MMIO window (or its absence, depending on DMEM_MMIO_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_dmem;

  logic        clk;
  logic        reset;
  logic        wr;
  logic        re;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  riscv_dmem #(
    .ADDR_BITS (10),
    .BUS_WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .re    (re),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr = 1'b0;
    re = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    wr    = 1'b1;
    re    = 1'b0;
    addr  = a;
    wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    wr   = 1'b0;
    re   = 1'b1;
    addr = a;
    #1;
    check(tag, rdata, exp);
    tick();
    re = 1'b0;
  endtask

  task automatic load_get(input logic [31:0] a, output logic [31:0] val);
    wr   = 1'b0;
    re   = 1'b1;
    addr = a;
    #1;
    val = rdata;
    tick();
    re = 1'b0;
  endtask

  logic [31:0] v0, v1;

  initial begin
    reset = 1'b1;
    wr    = 1'b0;
    re    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);

    // Store 0 then read it back.
    store(32'h0, 32'h0);
    idle(1);
    load_chk("zero_word", 32'h0, 32'h0);

    // re low drives zero even with an in-range address.
    addr = 32'h0000_0000;
    #1;
    check("re_low_zero", rdata, 32'h0);

    // Forwarding: prior array value differs from the buffered one.
    store(32'h10, 32'h0BAD_0BAD);
    idle(2);
    store(32'h10, 32'hDEAD_BEEF);
    load_chk("fwd_next_cycle", 32'h10, 32'hDEAD_BEEF);
    idle(2);
    load_chk("array_after_3", 32'h10, 32'hDEAD_BEEF);

    // Back-to-back stores, including a rewrite of the first address.
    store(32'h20, 32'h1111_1111);
    store(32'h24, 32'h2222_2222);
    store(32'h20, 32'h3333_3333);
    load_chk("b2b_fwd_20", 32'h20, 32'h3333_3333);
    idle(2);
    load_chk("b2b_arr_20", 32'h20, 32'h3333_3333);
    load_chk("b2b_arr_24", 32'h24, 32'h2222_2222);
    // Buffer now holds something else: 0x10 must come from the array.
    store(32'h28, 32'h7777_7777);
    load_chk("arr_other_idx", 32'h10, 32'hDEAD_BEEF);

    // Simultaneous load and store to the same word returns the old value.
    store(32'h30, 32'hAAAA_AAAA);
    idle(2);
    wr = 1'b1; re = 1'b1; addr = 32'h30; wdata = 32'hBBBB_BBBB;
    #1;
    check("rw_same_old", rdata, 32'hAAAA_AAAA);
    tick();
    wr = 1'b0; re = 1'b0;
    load_chk("rw_same_new", 32'h30, 32'hBBBB_BBBB);

    // Word 0 gets a recognisable value for the drop/retention checks.
    store(32'h0, 32'h5555_AAAA);
    idle(2);

    // Out-of-range load.
    check("err_before", {31'b0, err}, 32'h0);
    re = 1'b1; addr = 32'h0000_1000;
    #1;
    check("oor_rdata", rdata, 32'h0);
    check("oor_err_not_yet", {31'b0, err}, 32'h0);
    tick();
    re = 1'b0;
    check("oor_err_set", {31'b0, err}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("err_sticky", {31'b0, err}, 32'h1);
    end

    // Reset while a store is still buffered.
    store(32'h40, 32'h0123_4567);
    idle(2);
    store(32'h40, 32'hCAFE_F00D);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_err", {31'b0, err}, 32'h0);
    load_chk("rst_mid_old", 32'h40, 32'h0123_4567);
    load_chk("rst_retained", 32'h0, 32'h5555_AAAA);

    // Misaligned store is dropped and flags an error.
    store(32'h0000_0002, 32'hFFFF_FFFF);
    check("misalign_err", {31'b0, err}, 32'h1);
    idle(2);
    load_chk("misalign_drop", 32'h0, 32'h5555_AAAA);

`ifdef DMEM_MMIO_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_get(32'hFFFF_FFF0, v0);
    idle(4);
    load_get(32'hFFFF_FFF0, v1);
    check("cyc_delta", v1 - v0, 32'd5);
    check("mmio_no_err", {31'b0, err}, 32'h0);
    store(32'h50, 32'h1);
    store(32'h54, 32'h2);
    store(32'h58, 32'h3);
    idle(1);
    load_chk("store_cnt", 32'hFFFF_FFF4, 32'd3);
    load_chk("reserved_fc", 32'hFFFF_FFFC, 32'h0);
    load_chk("oor_for_clr", 32'h0000_1000, 32'h0);
    load_chk("err_reg_read", 32'hFFFF_FFF8, 32'h1);
    store(32'hFFFF_FFF8, 32'h0);
    check("err_cleared", {31'b0, err}, 32'h0);
    store(32'hFFFF_FFFC, 32'h1234_5678);
    check("reserved_st_ok", {31'b0, err}, 32'h0);
`else
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_chk("nommio_rdata", 32'hFFFF_FFF0, 32'h0);
    check("nommio_err", {31'b0, err}, 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
